stream_tag_splicer: RTL and testbench

- Next-generation splicer of a data stream and a check/tag stream (e.g. SHA/HMAC digest beats).
- Forwards payload beats from the input stream, then closes each packet with one beat taken from the check stream. The tag beat either replaces the final payload beat or is appended after it.
- Fully honours out_ready through a registered output stage.
- Adds packet and ID-mismatch accounting.
- Sits between the payload source and the hash engine output, in front of the network or host stream.

---
 rtl/stream_tag_splicer_pkg.sv | 15 +
 rtl/stream_out_reg.sv | 29 ++
 rtl/stream_tag_splicer.sv | 170 +++++++++++++++++
 tb/tb_stream_tag_splicer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_tag_splicer_pkg.sv
// Shared types and constants for the stream/tag splicer family.
package stream_tag_pkg;

    // Splicer control states: forwarding payload, holding the last payload
    // beat until its tag arrives (replace), or emitting an appended tag.
    typedef enum logic [1:0] {
        S_PASS = 2'd0,
        S_TAIL = 2'd1,
        S_TAG  = 2'd2
    } state_t;

    localparam int MODE_REPLACE = 0;
    localparam int MODE_APPEND  = 1;

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register. A new beat may load whenever the
// register is empty or its current beat is being taken downstream.
module stream_out_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    input  logic         push,
    output logic         load,
    output logic [W-1:0] q,
    output logic         valid,
    input  logic         ready
);

    assign load = !valid || ready;

    // Hold the beat while stalled; otherwise take the pushed beat (or empty).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= push;
            if (push) q <= d;
        end
    end

endmodule

// File: rtl/stream_tag_splicer.sv
// Splices one tag beat onto the end of every payload packet, either replacing
// the final payload beat or appending after it, with packet and id-mismatch
// accounting.
module stream_tag_splicer
    import stream_tag_pkg::*;
#(
    parameter  int DATA_W   = 512,
    parameter  int ID_W     = 6,
    parameter  int MODE     = 0,
    parameter  int CHECK_ID = 1,
    parameter  int CNT_W    = 32,
    localparam int KEEP_W   = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] inp_data,
    input  logic              inp_valid,
    output logic              inp_ready,
    input  logic [KEEP_W-1:0] inp_keep,
    input  logic [ID_W-1:0]   inp_id,
    input  logic              inp_last,
    input  logic [DATA_W-1:0] chk_data,
    input  logic              chk_valid,
    output logic              chk_ready,
    input  logic [KEEP_W-1:0] chk_keep,
    input  logic [ID_W-1:0]   chk_id,
    input  logic              chk_last,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [KEEP_W-1:0] out_keep,
    output logic [ID_W-1:0]   out_id,
    output logic              out_last,
    input  logic              err_clear,
    output logic [CNT_W-1:0]  pkt_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              id_err
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [ID_W-1:0]   id;
        logic              last;
    } beat_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state, state_nxt;
    beat_t           nxt, cur, tag_beat;
    logic            push, load, tag_hs;
    logic            first, cap;
    logic [ID_W-1:0] pkt_id;
    logic            mism;

    // Every tag beat is a single beat, so its last flag carries nothing.
    logic unused_chk_last;
    assign unused_chk_last = chk_last;

    assign tag_beat = '{data: chk_data, keep: chk_keep, id: chk_id, last: 1'b1};

    stream_out_reg #(.W($bits(beat_t))) u_out (
        .clock (clock),
        .reset (reset),
        .d     (nxt),
        .push  (push),
        .load  (load),
        .q     (cur),
        .valid (out_valid),
        .ready (out_ready)
    );

    assign out      = cur.data;
    assign out_keep = cur.keep;
    assign out_id   = cur.id;
    assign out_last = cur.last;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_PASS;
        else        state <= state_nxt;
    end

    // Next state, upstream readies and the beat offered to the output stage.
    always_comb begin
        state_nxt = state;
        inp_ready = 1'b0;
        chk_ready = 1'b0;
        push      = 1'b0;
        tag_hs    = 1'b0;
        nxt       = '{data: inp_data, keep: inp_keep, id: inp_id, last: 1'b0};
        case (state)
            S_PASS: begin
                if (inp_valid) begin
                    if (!inp_last) begin
                        if (load) begin
                            inp_ready = 1'b1;
                            push      = 1'b1;
                        end
                    end else if (MODE == MODE_REPLACE) begin
                        // Park the last beat; it is dropped when the tag lands.
                        state_nxt = S_TAIL;
                    end else if (load) begin
                        inp_ready = 1'b1;
                        push      = 1'b1;
                        state_nxt = S_TAG;
                    end
                end
            end
            S_TAIL: begin
                if (chk_valid && inp_valid && load) begin
                    inp_ready = 1'b1;
                    chk_ready = 1'b1;
                    push      = 1'b1;
                    tag_hs    = 1'b1;
                    nxt       = tag_beat;
                    state_nxt = S_PASS;
                end
            end
            S_TAG: begin
                if (chk_valid && load) begin
                    chk_ready = 1'b1;
                    push      = 1'b1;
                    tag_hs    = 1'b1;
                    nxt       = tag_beat;
                    state_nxt = S_PASS;
                end
            end
            default: state_nxt = S_PASS;
        endcase
    end

    // The packet id is taken from the first beat; in replace mode a one-beat
    // packet is never handshaken in S_PASS, so capture on entry to S_TAIL too.
    assign cap  = (state == S_PASS) && inp_valid && first &&
                  (inp_ready || ((MODE == MODE_REPLACE) && inp_last));
    assign mism = (CHECK_ID != 0) && tag_hs && (chk_id != pkt_id);

    // Track packet start and capture its id.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            first  <= 1'b1;
            pkt_id <= '0;
        end else begin
            if (tag_hs)   first <= 1'b1;
            else if (cap) first <= 1'b0;
            if (cap) pkt_id <= inp_id;
        end
    end

    // Packet completion count (wrapping) and id-mismatch accounting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_count <= '0;
            err_count <= '0;
            id_err    <= 1'b0;
        end else begin
            if (tag_hs) pkt_count <= pkt_count + CNT_ONE;
            if (err_clear) begin
                err_count <= '0;
                id_err    <= 1'b0;
            end else if (mism) begin
                id_err <= 1'b1;
                if (err_count != CNT_MAX) err_count <= err_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_stream_tag_splicer.sv
// Bench for stream_tag_splicer: one replace-mode and one append-mode instance
// share the stimulus buses; sel chooses which one is active.
module tb_stream_tag_splicer;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int IW = 6;
    localparam int CW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [IW-1:0] id;
        logic          last;
    } tb_beat_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          sel;
    logic [DW-1:0] inp_data, chk_data;
    logic [KW-1:0] inp_keep, chk_keep;
    logic [IW-1:0] inp_id, chk_id;
    logic          inp_valid, inp_last, chk_valid, chk_last, out_ready, err_clear;

    logic          ir0, cr0, ov0, ol0, ie0, ir1, cr1, ov1, ol1, ie1;
    logic [DW-1:0] od0, od1;
    logic [KW-1:0] ok0, ok1;
    logic [IW-1:0] oi0, oi1;
    logic [CW-1:0] pc0, ec0, pc1, ec1;

    logic          d_inp_ready, d_chk_ready, d_valid, d_last, d_iderr;
    logic [DW-1:0] d_out;
    logic [KW-1:0] d_keep;
    logic [IW-1:0] d_id;
    logic [CW-1:0] d_pkt, d_err;

    int checks = 0;
    int errors = 0;

    tb_beat_t      exp_q[$];
    logic [DW-1:0] obs_q[$];
    logic          obs_last[$];
    int            exp_pkt[2];
    int            exp_err[2];
    int            exp_iderr[2];
    logic          last_shown;
    logic          prev_hold = 1'b0;
    tb_beat_t      prev_beat;

    always #5 clock = ~clock;

    stream_tag_splicer #(.DATA_W(DW), .ID_W(IW), .MODE(0), .CHECK_ID(1), .CNT_W(CW)) u_m0 (
        .clock(clock), .reset(reset),
        .inp_data(inp_data), .inp_valid(inp_valid & ~sel), .inp_ready(ir0),
        .inp_keep(inp_keep), .inp_id(inp_id), .inp_last(inp_last),
        .chk_data(chk_data), .chk_valid(chk_valid & ~sel), .chk_ready(cr0),
        .chk_keep(chk_keep), .chk_id(chk_id), .chk_last(chk_last),
        .out(od0), .out_valid(ov0), .out_ready(out_ready), .out_keep(ok0),
        .out_id(oi0), .out_last(ol0), .err_clear(err_clear),
        .pkt_count(pc0), .err_count(ec0), .id_err(ie0)
    );

    stream_tag_splicer #(.DATA_W(DW), .ID_W(IW), .MODE(1), .CHECK_ID(1), .CNT_W(CW)) u_m1 (
        .clock(clock), .reset(reset),
        .inp_data(inp_data), .inp_valid(inp_valid & sel), .inp_ready(ir1),
        .inp_keep(inp_keep), .inp_id(inp_id), .inp_last(inp_last),
        .chk_data(chk_data), .chk_valid(chk_valid & sel), .chk_ready(cr1),
        .chk_keep(chk_keep), .chk_id(chk_id), .chk_last(chk_last),
        .out(od1), .out_valid(ov1), .out_ready(out_ready), .out_keep(ok1),
        .out_id(oi1), .out_last(ol1), .err_clear(err_clear),
        .pkt_count(pc1), .err_count(ec1), .id_err(ie1)
    );

    assign d_inp_ready = sel ? ir1 : ir0;
    assign d_chk_ready = sel ? cr1 : cr0;
    assign d_valid     = sel ? ov1 : ov0;
    assign d_out       = sel ? od1 : od0;
    assign d_keep      = sel ? ok1 : ok0;
    assign d_id        = sel ? oi1 : oi0;
    assign d_last      = sel ? ol1 : ol0;
    assign d_pkt       = sel ? pc1 : pc0;
    assign d_err       = sel ? ec1 : ec0;
    assign d_iderr     = sel ? ie1 : ie0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Output scoreboard: every accepted beat must match the model, a stalled
    // beat must not change, and upstream must be held off while stalled.
    always @(negedge clock) begin
        tb_beat_t cur, e;
        cur = '{data: d_out, keep: d_keep, id: d_id, last: d_last};
        if (reset) begin
            if (prev_hold) begin
                chk("stall_valid", d_valid, 1);
                chk("stall_fields", cur, prev_beat);
            end
            if (d_valid && !out_ready) begin
                chk("inp_ready_full", d_inp_ready, 0);
                chk("chk_ready_full", d_chk_ready, 0);
            end
            if (!sel && inp_valid && inp_last)
                chk("tail_joint_ready", d_inp_ready, d_chk_ready);
            if (d_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_beat");
                else begin
                    e = exp_q.pop_front();
                    chk("out_beat", cur, e);
                end
                obs_q.push_back(d_out);
                obs_last.push_back(d_last);
            end
            prev_hold = d_valid && !out_ready;
            prev_beat = cur;
        end else prev_hold = 1'b0;
    end

    task automatic wait_hs(input bit is_chk, input string name);
        bit hs;
        int cnt;
        hs  = 1'b0;
        cnt = 0;
        while (!hs && cnt < 100) begin
            @(negedge clock);
            hs = is_chk ? d_chk_ready : d_inp_ready;
            @(posedge clock);
            #1;
            cnt++;
        end
        if (!hs) fail_now({name, "_timeout"});
    endtask

    // Drive one packet of n payload beats plus its tag and queue the beats
    // the splicer must emit for that mode.
    task automatic send_pkt(input int m, input int n, input logic [DW-1:0] base,
                            input logic [IW-1:0] pid, input logic [DW-1:0] tag,
                            input logic [IW-1:0] tid, input int tdel, input bit clr);
        tb_beat_t b;
        sel = m[0];
        for (int i = 0; i < n; i++) begin
            if (m == 1 || i < n - 1) begin
                b = '{data: base + DW'(i), keep: 4'hF, id: pid, last: 1'b0};
                exp_q.push_back(b);
            end
        end
        b = '{data: tag, keep: 4'h3, id: tid, last: 1'b1};
        exp_q.push_back(b);
        exp_pkt[m] = (exp_pkt[m] + 1) % (1 << CW);
        if (tid != pid) begin
            exp_iderr[m] = 1;
            if (exp_err[m] < (1 << CW) - 1) exp_err[m]++;
        end
        if (clr) begin
            exp_err[m]   = 0;
            exp_iderr[m] = 0;
        end
        last_shown = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    inp_data  = base + DW'(i);
                    inp_keep  = 4'hF;
                    inp_id    = pid;
                    inp_last  = (i == n - 1);
                    inp_valid = 1'b1;
                    if (i == n - 1) last_shown = 1'b1;
                    wait_hs(1'b0, "inp_hs");
                end
                inp_valid = 1'b0;
                inp_last  = 1'b0;
            end
            begin
                wait (last_shown == 1'b1);
                for (int k = 0; k < tdel; k++) begin
                    @(negedge clock);
                    if (m == 0) chk("tail_wait_inp_ready", d_inp_ready, 0);
                    @(posedge clock);
                    #1;
                end
                chk_data  = tag;
                chk_keep  = 4'h3;
                chk_id    = tid;
                chk_last  = 1'b1;
                chk_valid = 1'b1;
                err_clear = clr;
                wait_hs(1'b1, "chk_hs");
                chk_valid = 1'b0;
                err_clear = 1'b0;
            end
        join
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || d_valid) && cnt < 200) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        if (cnt >= 200) fail_now("drain_timeout");
    endtask

    task automatic check_counters(input int m);
        chk("pkt_count", d_pkt, exp_pkt[m]);
        chk("err_count", d_err, exp_err[m]);
        chk("id_err", d_iderr, exp_iderr[m]);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; sel = 1'b0; out_ready = 1'b1; err_clear = 1'b0;
        inp_data = '0; inp_keep = '0; inp_id = '0; inp_valid = 1'b0; inp_last = 1'b0;
        chk_data = '0; chk_keep = '0; chk_id = '0; chk_valid = 1'b0; chk_last = 1'b0;
        for (int m = 0; m < 2; m++) begin
            exp_pkt[m] = 0; exp_err[m] = 0; exp_iderr[m] = 0;
        end
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid0", ov0, 0);
        chk("rst_valid1", ov1, 0);
        chk("rst_out0", {od0, ok0, oi0, ol0}, 0);
        chk("rst_cnt0", {pc0, ec0, ie0}, 0);
        chk("rst_cnt1", {pc1, ec1, ie1}, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Replace mode, 3-beat packet.
        obs_q.delete(); obs_last.delete();
        send_pkt(0, 3, 32'hA1, 6'd5, 32'hFF, 6'd5, 0, 1'b0);
        drain();
        chk("t1_nbeats", obs_q.size(), 3);
        chk("t1_b0", obs_q[0], 32'hA1);
        chk("t1_b1", obs_q[1], 32'hA2);
        chk("t1_b2", obs_q[2], 32'hFF);
        chk("t1_last", {obs_last[0], obs_last[1], obs_last[2]}, 3'b001);
        chk("t1_pkt_lit", d_pkt, 1);
        chk("t1_iderr_lit", d_iderr, 0);
        check_counters(0);

        // Append mode, same stimulus.
        obs_q.delete(); obs_last.delete();
        send_pkt(1, 3, 32'hA1, 6'd5, 32'hFF, 6'd5, 0, 1'b0);
        drain();
        chk("t2_nbeats", obs_q.size(), 4);
        chk("t2_b2", obs_q[2], 32'hA3);
        chk("t2_b3", obs_q[3], 32'hFF);
        chk("t2_last", {obs_last[2], obs_last[3]}, 2'b01);
        chk("t2_pkt_lit", d_pkt, 1);
        check_counters(1);

        // Backpressure mid-packet.
        obs_q.delete(); obs_last.delete();
        fork
            send_pkt(0, 4, 32'h10, 6'd3, 32'h20, 6'd3, 0, 1'b0);
            begin
                repeat (2) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("t3_nbeats", obs_q.size(), 4);
        check_counters(0);

        // Late tag in replace mode.
        send_pkt(0, 2, 32'h30, 6'd9, 32'h40, 6'd9, 6, 1'b0);
        drain();
        check_counters(0);

        // Id mismatch, then a clear coinciding with a second mismatch.
        obs_q.delete(); obs_last.delete();
        send_pkt(0, 1, 32'h50, 6'd5, 32'h60, 6'd7, 0, 1'b0);
        drain();
        chk("t5_nbeats", obs_q.size(), 1);
        chk("t5_tag_lit", obs_q[0], 32'h60);
        chk("t5_iderr_lit", d_iderr, 1);
        chk("t5_err_lit", d_err, 1);
        check_counters(0);
        send_pkt(0, 1, 32'h52, 6'd5, 32'h62, 6'd7, 0, 1'b1);
        drain();
        chk("t5_clr_iderr_lit", d_iderr, 0);
        chk("t5_clr_err_lit", d_err, 0);
        check_counters(0);

        // Single-beat packet in append mode.
        obs_q.delete(); obs_last.delete();
        send_pkt(1, 1, 32'h70, 6'd2, 32'h71, 6'd2, 0, 1'b0);
        drain();
        chk("t6_nbeats", obs_q.size(), 2);
        check_counters(1);

        // Counter wrap and error saturation.
        for (int k = 0; k < 8; k++) begin
            send_pkt(1, 1, 32'h100 + DW'(k), 6'd1, 32'h200 + DW'(k), 6'd2, 0, 1'b0);
            drain();
        end
        chk("t7_pkt_wrap_lit", d_pkt, 2);
        chk("t7_err_sat_lit", d_err, 7);
        check_counters(1);

        // Reset in the middle of a packet.
        sel = 1'b0;
        inp_data = 32'h80; inp_keep = 4'hF; inp_id = 6'd11; inp_last = 1'b0; inp_valid = 1'b1;
        exp_q.push_back('{data: 32'h80, keep: 4'hF, id: 6'd11, last: 1'b0});
        wait_hs(1'b0, "t8_inp_hs");
        inp_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("t8_pre_valid", ov0, 1);
        reset = 1'b0;
        #1;
        chk("t8_rst_valid", ov0, 0);
        exp_q.delete();
        for (int m = 0; m < 2; m++) begin
            exp_pkt[m] = 0; exp_err[m] = 0; exp_iderr[m] = 0;
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        obs_q.delete(); obs_last.delete();
        send_pkt(0, 3, 32'h90, 6'd4, 32'h99, 6'd4, 0, 1'b0);
        drain();
        chk("t8_nbeats", obs_q.size(), 3);
        chk("t8_pkt_lit", d_pkt, 1);
        check_counters(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
